// File: rtl/wb_scoreboard.sv
// Register write-back scoreboard: tracks in-flight writes from issue to register-file
// visibility and raises the decode freeze. Optional macro WB_SCOREBOARD_FWD_EN limits freeze to load-use.
module wb_scoreboard #(
  parameter int DEPTH = 2,
  parameter int NREG  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             flush,
  input  logic             issue_wb_en,
  input  logic             issue_is_load,
  input  logic [3:0]       issue_dest,
  input  logic [3:0]       rn,
  input  logic [3:0]       rm,
  input  logic             two_src,
  output logic             freeze,
  output logic [NREG-1:0]  pending_mask,
  output logic [DEPTH-1:0] slot_valid,
  output logic             err_ovf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [DEPTH-1:0] slot_valid_q, slot_valid_d;
  logic [DEPTH-1:0] slot_load_q, slot_load_d;
  logic [3:0]       slot_dest_q [DEPTH];
  logic [3:0]       slot_dest_d [DEPTH];
  logic [CW-1:0]    cnt_q [NREG];
  logic [CW-1:0]    cnt_d [NREG];
  logic             err_ovf_q, err_ovf_d;

  logic             issue_fire;
  logic             retire;
  logic [3:0]       retire_dest;
  logic             unused_load;

  assign issue_fire  = advance & issue_wb_en & ~freeze & ~flush;
  assign retire      = advance & slot_valid_q[DEPTH-1];
  assign retire_dest = slot_dest_q[DEPTH-1];
  // The last slot's load flag is never consumed: it only matters while in EXE.
  assign unused_load = slot_load_q[DEPTH-1];

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_load_d  = slot_load_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_dest_d[i] = slot_dest_q[i];
    end
    if (advance) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        slot_valid_d[i] = slot_valid_q[i-1];
        slot_load_d[i]  = slot_load_q[i-1];
        slot_dest_d[i]  = slot_dest_q[i-1];
      end
      slot_valid_d[0] = issue_fire;
      slot_load_d[0]  = issue_is_load;
      slot_dest_d[0]  = issue_dest;
    end
  end

  always_comb begin
    err_ovf_d = err_ovf_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      logic inc, dec;
      cnt_d[r] = cnt_q[r];
      inc = issue_fire && (issue_dest == 4'(r));
      dec = retire && (retire_dest == 4'(r));
      if (inc && !dec) begin
        if (cnt_q[r] == CNT_MAX) begin
          err_ovf_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      pending_mask[r] = (cnt_q[r] != '0);
    end
  end

`ifdef WB_SCOREBOARD_FWD_EN
  // Forwarding covers ALU results; only a load still in EXE must hold decode.
  assign freeze = slot_valid_q[0] & slot_load_q[0] &
                  ((slot_dest_q[0] == rn) | (two_src & (slot_dest_q[0] == rm)));
`else
  assign freeze = pending_mask[rn] | (two_src & pending_mask[rm]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= '0;
      slot_load_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_dest_q[i] <= '0;
      end
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      err_ovf_q <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_load_q  <= slot_load_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_dest_q[i] <= slot_dest_d[i];
      end
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_ovf_q <= err_ovf_d;
    end
  end

  assign slot_valid = slot_valid_q;
  assign err_ovf    = err_ovf_q;

endmodule
